// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared FSM encoding, parameter defaults and constants for the decode-stage
// hazard controller and its scoreboard compare cells.
package pipe_hazard_ctrl_pkg;

  localparam int SB_DEPTH_DEF  = 3;
  localparam int STALL_MAX_DEF = 3;
  localparam int REG_W         = 3;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// Compares one decode source register against one {valid, reg} scoreboard
// entry; purely combinational.
module sb_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             entry_valid,
  input  logic [REG_W-1:0] entry_reg,
  output logic             hit
);

  assign hit = entry_valid && (src == entry_reg);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: RAW stall against an in-flight write
// scoreboard, branch flush, HALT drain and sticky protocol-error reporting.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int SB_DEPTH  = SB_DEPTH_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_RsUsed,
  input  logic [2:0]  dec_Rs,
  input  logic        dec_RtUsed,
  input  logic [2:0]  dec_Rt,
  input  logic        dec_RegWrite,
  input  logic [2:0]  dec_writeRegSel,
  input  logic        dec_PCSrc,
  input  logic        dec_HaltPC,
  output logic        pcEn,
  output logic        ftchDecEn,
  output logic        ftchFlush,
  output logic        decBubble,
  output logic        decExeEn,
  output logic        exeMemEn,
  output logic        memWbEn,
  output logic        halted,
  output logic [15:0] stallCnt,
  output logic        err
);

  localparam int                RUN_W      = $clog2(STALL_MAX + 2);
  localparam logic [RUN_W-1:0]  RUN_LIMIT  = RUN_W'(STALL_MAX);
  localparam logic [RUN_W-1:0]  RUN_ONE    = RUN_W'(1);
  localparam logic [1:0]        DRAIN_LAST = 2'(SB_DEPTH - 1);

  ctrl_state_t                    state;
  logic [1:0]                     drain_cnt;
  logic [SB_DEPTH-1:0]            sb_valid;
  logic [SB_DEPTH-1:0][REG_W-1:0] sb_reg;
  logic [SB_DEPTH-1:0]            rs_hit;
  logic [SB_DEPTH-1:0]            rt_hit;
  logic [RUN_W-1:0]               stall_run;
  logic                           stall;
  logic                           sb_load;

  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_match
    sb_match u_rs_match (
      .src         (dec_Rs),
      .entry_valid (sb_valid[i]),
      .entry_reg   (sb_reg[i]),
      .hit         (rs_hit[i])
    );
    sb_match u_rt_match (
      .src         (dec_Rt),
      .entry_valid (sb_valid[i]),
      .entry_reg   (sb_reg[i]),
      .hit         (rt_hit[i])
    );
  end

  // No write-to-read bypass exists, so every valid entry including WB blocks
  // a reader; outside RUN the decode slot is frozen and cannot hazard.
  assign stall   = (state == RUN) &&
                   ((dec_RsUsed && |rs_hit) || (dec_RtUsed && |rt_hit));
  assign sb_load = dec_RegWrite && (state == RUN) && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      sb_reg   <= '0;
    end else begin
      for (int i = SB_DEPTH - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_reg[i]   <= sb_reg[i-1];
      end
      sb_valid[0] <= sb_load;
      sb_reg[0]   <= dec_writeRegSel;
    end
  end

  // HALT only commits once its own operands are clean; DRAIN then lets the
  // in-flight instructions retire before everything freezes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dec_HaltPC && !stall) begin
            state     <= DRAIN;
            drain_cnt <= 2'd0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // A branch resolved under a stall uses stale operands, so the flush waits
  // for the first clean cycle, which is simply the next non-stall RUN cycle.
  always_comb begin
    pcEn      = 1'b1;
    ftchDecEn = 1'b1;
    ftchFlush = 1'b0;
    decBubble = 1'b0;
    decExeEn  = 1'b1;
    exeMemEn  = 1'b1;
    memWbEn   = 1'b1;
    case (state)
      RUN: begin
        if (stall) begin
          pcEn      = 1'b0;
          ftchDecEn = 1'b0;
          decBubble = 1'b1;
        end else begin
          ftchFlush = dec_PCSrc;
        end
      end
      DRAIN: begin
        pcEn      = 1'b0;
        ftchDecEn = 1'b0;
        decBubble = 1'b1;
      end
      HALT: begin
        pcEn      = 1'b0;
        ftchDecEn = 1'b0;
        decExeEn  = 1'b0;
        exeMemEn  = 1'b0;
        memWbEn   = 1'b0;
      end
      default: begin
        pcEn = 1'b1;
      end
    endcase
  end

  // The run counter saturates one past the limit so a stuck match cannot
  // wrap it back into the legal range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_run <= '0;
      stallCnt  <= 16'd0;
      err       <= 1'b0;
    end else begin
      if (stall) begin
        stallCnt <= stallCnt + 16'd1;
        if (stall_run <= RUN_LIMIT) begin
          stall_run <= stall_run + RUN_ONE;
        end
      end else begin
        stall_run <= '0;
      end
      if ((stall && (stall_run >= RUN_LIMIT)) || ((state == HALT) && dec_HaltPC)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// decode traffic compared against a cycle-distance reference model.
module tb_pipe_hazard_ctrl;

  localparam int SB_DEPTH  = 3;
  localparam int STALL_MAX = 3;
  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_HALT    = 2;

  localparam logic [6:0] VEC_RUN   = 7'b1111100;
  localparam logic [6:0] VEC_STALL = 7'b0011101;
  localparam logic [6:0] VEC_HALT  = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rs_used, rt_used, reg_write, pc_src, halt_pc;
  logic [2:0] rs, rt, wsel;

  logic        pcEn, ftchDecEn, ftchFlush, decBubble, decExeEn, exeMemEn, memWbEn;
  logic        halted, err;
  logic [15:0] stallCnt;
  logic        pcEn_4, ftchDecEn_4, ftchFlush_4, decBubble_4, decExeEn_4, exeMemEn_4, memWbEn_4;
  logic        halted_4, err_4;
  logic [15:0] stallCnt_4;
  logic [6:0]  out_vec;

  assign out_vec = {pcEn, ftchDecEn, decExeEn, exeMemEn, memWbEn, ftchFlush, decBubble};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .dec_RsUsed(rs_used), .dec_Rs(rs), .dec_RtUsed(rt_used), .dec_Rt(rt),
    .dec_RegWrite(reg_write), .dec_writeRegSel(wsel),
    .dec_PCSrc(pc_src), .dec_HaltPC(halt_pc),
    .pcEn(pcEn), .ftchDecEn(ftchDecEn), .ftchFlush(ftchFlush), .decBubble(decBubble),
    .decExeEn(decExeEn), .exeMemEn(exeMemEn), .memWbEn(memWbEn),
    .halted(halted), .stallCnt(stallCnt), .err(err)
  );

  // Deeper scoreboard lets a genuine match persist past the stall limit.
  pipe_hazard_ctrl #(.SB_DEPTH(4), .STALL_MAX(3)) dut4 (
    .clk(clk), .rst(rst),
    .dec_RsUsed(rs_used), .dec_Rs(rs), .dec_RtUsed(rt_used), .dec_Rt(rt),
    .dec_RegWrite(reg_write), .dec_writeRegSel(wsel),
    .dec_PCSrc(pc_src), .dec_HaltPC(halt_pc),
    .pcEn(pcEn_4), .ftchDecEn(ftchDecEn_4), .ftchFlush(ftchFlush_4), .decBubble(decBubble_4),
    .decExeEn(decExeEn_4), .exeMemEn(exeMemEn_4), .memWbEn(memWbEn_4),
    .halted(halted_4), .stallCnt(stallCnt_4), .err(err_4)
  );

  int checks;
  int failures;

  int          cyc;
  int          last_wr [8];
  int          mode;
  int          drain_left;
  int          consec;
  logic [15:0] e_total;
  logic        err_m;
  logic        e_stall;
  logic [6:0]  e_vec;

  function automatic void model_reset();
    cyc = 0;
    for (int i = 0; i < 8; i++) last_wr[i] = -1000;
    mode = M_RUN;
    drain_left = 0;
    consec = 0;
    e_total = 16'd0;
    err_m = 1'b0;
  endfunction

  // A reader hazards while its register was issued within the last SB_DEPTH cycles.
  function automatic void model_eval();
    logic rs_haz, rt_haz;
    rs_haz = rs_used && ((cyc - last_wr[rs]) <= SB_DEPTH);
    rt_haz = rt_used && ((cyc - last_wr[rt]) <= SB_DEPTH);
    e_stall = (mode == M_RUN) && (rs_haz || rt_haz);
    if (mode == M_HALT)       e_vec = VEC_HALT;
    else if (mode == M_DRAIN) e_vec = VEC_STALL;
    else if (e_stall)         e_vec = VEC_STALL;
    else                      e_vec = {5'b11111, pc_src, 1'b0};
  endfunction

  function automatic void model_advance();
    model_eval();
    if (e_stall) begin
      e_total = e_total + 16'd1;
      consec++;
      if (consec > STALL_MAX) err_m = 1'b1;
    end else begin
      consec = 0;
    end
    if (mode == M_HALT && halt_pc) err_m = 1'b1;
    if (mode == M_RUN && !e_stall && reg_write) last_wr[wsel] = cyc;
    if (mode == M_RUN && halt_pc && !e_stall) begin
      mode = M_DRAIN;
      drain_left = SB_DEPTH;
    end else if (mode == M_DRAIN) begin
      drain_left--;
      if (drain_left == 0) mode = M_HALT;
    end
    cyc++;
  endfunction

  task automatic set_in(input logic a_rsu, input logic [2:0] a_rs, input logic a_rtu,
                        input logic [2:0] a_rt, input logic a_rw, input logic [2:0] a_ws,
                        input logic a_pcs, input logic a_halt);
    rs_used = a_rsu; rs = a_rs; rt_used = a_rtu; rt = a_rt;
    reg_write = a_rw; wsel = a_ws; pc_src = a_pcs; halt_pc = a_halt;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rs_used = 0; rs = 0; rt_used = 0; rt = 0; reg_write = 0; wsel = 0; pc_src = 0; halt_pc = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_vec !== VEC_RUN) begin failures++; $display("[TB] FAIL reset_enables: got %b expected %b", out_vec, VEC_RUN); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_stallcnt: got %0d expected 0", stallCnt); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_raw_hazard();
    int stalls;
    set_in(0, 0, 0, 0, 1, 3'd1, 0, 0);
    checks++; if (pcEn !== 1'b1) begin failures++; $display("[TB] FAIL raw_producer_pcen: got %b expected 1", pcEn); end
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 3'd1, 0, 0, 1, 3'd3, 0, 0);
      checks++; if (pcEn !== (k >= 3)) begin failures++; $display("[TB] FAIL raw_d1_pcen[%0d]: got %b expected %b", k, pcEn, (k >= 3)); end
      checks++; if (decBubble !== (k < 3)) begin failures++; $display("[TB] FAIL raw_d1_bubble[%0d]: got %b expected %b", k, decBubble, (k < 3)); end
      if (k == 3) begin
        checks++; if (stallCnt !== 16'd3) begin failures++; $display("[TB] FAIL raw_d1_stallcnt: got %0d expected 3", stallCnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL raw_d1_err: got %b expected 0", err); end
      end
      tick();
    end
    for (int d = 2; d <= 4; d++) begin
      repeat (4) begin set_in(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
      set_in(0, 0, 0, 0, 1, 3'(d), 0, 0);
      tick();
      repeat (d - 1) begin set_in(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
      stalls = 0;
      for (int k = 0; k < 8; k++) begin
        set_in(0, 0, 1, 3'(d), 0, 0, 0, 0);
        if (pcEn === 1'b1) break;
        stalls++;
        tick();
      end
      tick();
      checks++; if (stalls != 4 - d) begin failures++; $display("[TB] FAIL raw_distance%0d_stalls: got %0d expected %0d", d, stalls, 4 - d); end
    end
  endtask

  task automatic test_flush();
    repeat (4) begin set_in(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    checks++; if ({ftchFlush, pcEn} !== 2'b11) begin failures++; $display("[TB] FAIL flush_clean: got flush/pcen %b expected 11", {ftchFlush, pcEn}); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ftchFlush !== 1'b0) begin failures++; $display("[TB] FAIL flush_one_cycle: got %b expected 0", ftchFlush); end
    tick();
    set_in(0, 0, 0, 0, 1, 3'd5, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 3'd5, 0, 0, 0, 0, 1, 0);
      checks++; if ({ftchFlush, pcEn} !== {(k == 3), (k == 3)}) begin failures++; $display("[TB] FAIL flush_under_stall[%0d]: got flush/pcen %b expected %b", k, {ftchFlush, pcEn}, {(k == 3), (k == 3)}); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ftchFlush !== 1'b0) begin failures++; $display("[TB] FAIL flush_after_stall: got %b expected 0", ftchFlush); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'b0);
      checks++; if (out_vec !== e_vec) begin failures++; $display("[TB] FAIL random_outputs[%0d]: got %b expected %b", n, out_vec, e_vec); end
      checks++; if (stallCnt !== e_total) begin failures++; $display("[TB] FAIL random_stallcnt[%0d]: got %0d expected %0d", n, stallCnt, e_total); end
      checks++; if (err !== err_m) begin failures++; $display("[TB] FAIL random_err[%0d]: got %b expected %b", n, err, err_m); end
      tick();
    end
  endtask

  task automatic test_halt();
    repeat (4) begin set_in(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    set_in(0, 0, 0, 0, 1, 3'd6, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 3'd6, 0, 0, 0, 0, 0, 1);
      checks++; if (out_vec !== ((k < 3) ? VEC_STALL : VEC_RUN)) begin failures++; $display("[TB] FAIL halt_under_stall[%0d]: got %b expected %b", k, out_vec, ((k < 3) ? VEC_STALL : VEC_RUN)); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if ({out_vec, halted} !== {VEC_STALL, 1'b0}) begin failures++; $display("[TB] FAIL halt_drain[%0d]: got %b expected %b", k, {out_vec, halted}, {VEC_STALL, 1'b0}); end
      checks++; if (out_vec !== e_vec) begin failures++; $display("[TB] FAIL halt_drain_model[%0d]: got %b expected %b", k, out_vec, e_vec); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if ({out_vec, halted, err} !== {VEC_HALT, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL halt_frozen[%0d]: got %b expected %b", k, {out_vec, halted, err}, {VEC_HALT, 1'b1, 1'b0}); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL halt_err_early: got %b expected 0", err); end
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if ({err, halted} !== 2'b11) begin failures++; $display("[TB] FAIL halt_again_err[%0d]: got err/halted %b expected 11", k, {err, halted}); end
      checks++; if (err !== err_m) begin failures++; $display("[TB] FAIL halt_err_model[%0d]: got %b expected %b", k, err, err_m); end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    repeat (2) begin set_in(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    set_in(0, 0, 0, 0, 1, 3'd4, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_vec !== VEC_STALL) begin failures++; $display("[TB] FAIL middrain_in_drain: got %b expected %b", out_vec, VEC_STALL); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({out_vec, halted, err} !== {VEC_RUN, 1'b0, 1'b0}) begin failures++; $display("[TB] FAIL middrain_during_reset: got %b expected %b", {out_vec, halted, err}, {VEC_RUN, 1'b0, 1'b0}); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_in(1, 3'd4, 0, 0, 0, 0, 0, 0);
    checks++; if ({out_vec, halted, stallCnt} !== {VEC_RUN, 1'b0, 16'd0}) begin failures++; $display("[TB] FAIL middrain_after_release: got %b expected %b", {out_vec, halted, stallCnt}, {VEC_RUN, 1'b0, 16'd0}); end
    tick();
  endtask

  task automatic test_stall_overflow();
    apply_reset();
    set_in(0, 0, 0, 0, 1, 3'd1, 0, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      set_in(1, 3'd1, 0, 0, 0, 0, 0, 0);
      checks++; if (pcEn_4 !== (k >= 4)) begin failures++; $display("[TB] FAIL overflow_pcen4[%0d]: got %b expected %b", k, pcEn_4, (k >= 4)); end
      checks++; if (err_4 !== (k >= 4)) begin failures++; $display("[TB] FAIL overflow_err4[%0d]: got %b expected %b", k, err_4, (k >= 4)); end
      checks++; if ({pcEn, err} !== {(k >= 3), 1'b0}) begin failures++; $display("[TB] FAIL overflow_default[%0d]: got pcen/err %b expected %b", k, {pcEn, err}, {(k >= 3), 1'b0}); end
      tick();
    end
    repeat (3) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (err_4 !== 1'b1) begin failures++; $display("[TB] FAIL overflow_sticky: got %b expected 1", err_4); end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++; if (err_4 !== 1'b0) begin failures++; $display("[TB] FAIL overflow_reset_clear: got %b expected 0", err_4); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    rs_used = 0; rs = 0; rt_used = 0; rt = 0; reg_write = 0; wsel = 0; pc_src = 0; halt_pc = 0;
    model_reset();
    test_reset();
    test_raw_hazard();
    test_flush();
    test_random();
    test_halt();
    test_reset_mid_drain();
    test_stall_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 3: number of in-flight stages tracked (EXE, MEM, WB).
REQ-002 SHALL have parameter STALL_MAX, default 3: longest legal run of consecutive stall cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 dec_RsUsed  input  1  decode instruction reads Rs.
REQ-007 dec_Rs  input  3  decode source register 1.
REQ-008 dec_RtUsed  input  1  decode instruction reads Rt.
REQ-009 dec_Rt  input  3  decode source register 2.
REQ-010 dec_RegWrite  input  1  decode instruction writes the register file.
REQ-011 dec_writeRegSel  input  3  decode destination register.
REQ-012 dec_PCSrc  input  1  taken branch or jump resolved in decode.
REQ-013 dec_HaltPC  input  1  HALT is in decode.
REQ-014 pcEn  output  1  PC register load enable.
REQ-015 ftchDecEn  output  1  fetch/decode pipeline register enable.
REQ-016 ftchFlush  output  1  load NOP into the fetch/decode register.
REQ-017 decBubble  output  1  load NOP (RegWrite=0, DMemEn=0) into the decode/execute register.
REQ-018 decExeEn, exeMemEn, memWbEn  output  1 each  downstream pipeline register enables.
REQ-019 halted  output  1  pipeline drained after HALT.
REQ-020 stallCnt  output  16  total stall cycles since reset, wraps at 16'hFFFF -> 0.
REQ-021 err  output  1  sticky protocol-violation flag.

Function
REQ-022 Scoreboard SHALL be a SB_DEPTH-entry shift register of {valid, reg[2:0]}; entry 0 (EXE) loads {dec_RegWrite & ~stall & ~decBubble-cause, dec_writeRegSel} each cycle; entries shift toward WB each cycle.
REQ-023 stall SHALL be 1 when (dec_RsUsed and dec_Rs matches any valid entry) or (dec_RtUsed and dec_Rt matches any valid entry); the register file has no write-to-read bypass, so the WB entry counts.
REQ-024 During stall: pcEn=0, ftchDecEn=0, decBubble=1, and scoreboard entry 0 loads invalid; decExeEn, exeMemEn, memWbEn stay 1.
REQ-025 A dependent instruction immediately after its producer SHALL stall exactly 3 cycles; at distance 2 it stalls 2, at distance 3 it stalls 1, at distance >=4 it stalls 0.
REQ-026 When dec_PCSrc=1 and stall=0, ftchFlush SHALL be 1 for that cycle only; pcEn stays 1.
REQ-027 When stall=1, dec_PCSrc SHALL be ignored because its operands are stale; the flush happens on the first non-stall cycle.
REQ-028 FSM states: RUN, DRAIN, HALT.
REQ-029 RUN -> DRAIN when dec_HaltPC=1 and stall=0.
REQ-030 In DRAIN: pcEn=0, ftchDecEn=0, decBubble=1; a 2-bit counter counts SB_DEPTH cycles, then the FSM moves to HALT.
REQ-031 In HALT: halted=1 and all enables are 0; the FSM leaves HALT only on reset.
REQ-032 dec_HaltPC together with stall=1 SHALL stall first; DRAIN starts on the first non-stall cycle.
REQ-033 A consecutive-stall counter SHALL increment on each stall cycle and clear otherwise; err sets when the counter exceeds STALL_MAX.
REQ-034 err SHALL also set when dec_HaltPC=1 while the FSM is in HALT.
REQ-035 In RUN with stall=0 and no flush, all enables SHALL be 1 and ftchFlush=decBubble=0.

Reset
REQ-036 While rst=0, regardless of clk: state=RUN, all scoreboard entries invalid, counters 0, stallCnt=0, err=0, halted=0.
REQ-037 During and immediately after reset: pcEn=ftchDecEn=decExeEn=exeMemEn=memWbEn=1, ftchFlush=decBubble=0.
REQ-038 Reset asserted mid-stall or mid-DRAIN SHALL abandon the operation with no residual stall on the first cycle after release.

Structure
REQ-039 Shared package SHALL hold the FSM state encoding (RUN=2'b00, DRAIN=2'b01, HALT=2'b10), the NOP instruction constant 16'h0800, and SB_DEPTH/STALL_MAX defaults.
REQ-040 SHALL use one sub-module, sb_match: combinational compare of a 3-bit source against one {valid, reg} scoreboard entry; instantiated 2 x SB_DEPTH times.

Verification
REQ-041 ADD r1 at cycle 0, ADD using r1 as Rs at cycle 1 -> stall=1 for cycles 1-3, pcEn=0, decBubble=1, stallCnt=3, err=0.
REQ-042 Producer r2, two independent instructions, then consumer of r2 -> exactly 1 stall cycle.
REQ-043 dec_PCSrc=1 with no hazard -> ftchFlush=1 for one cycle; dec_PCSrc=1 coincident with stall -> flush only on the cycle after stall clears.
REQ-044 dec_HaltPC=1 -> DRAIN for 3 cycles, then halted=1 and all enables 0; a later dec_HaltPC=1 -> err=1.
REQ-045 Force scoreboard match held 4 cycles -> err=1 on the 4th stall cycle and remains 1 until rst=0.
REQ-046 Assert rst=0 during cycle 2 of DRAIN -> state=RUN, halted=0, scoreboard invalid; all enables 1 on the first cycle after release.
